priority_decoder: RTL and testbench
===================================

# priority_decoder

Sequential inverse of the 8-line active-low priority encoder. Accepts a 4-bit line code (0 = no line, 1..8 = line index + 1) over a valid/ready handshake. Drives the matching active-low one-hot line pattern for a fixed number of cycles, then inserts an idle gap. Used to replay encoded line events onto 8 active-low lines so that an encoder downstream recovers the original code.

## Interface
- HOLD_CYCLES, 4, cycles a decoded pattern is driven; legal range 1..255
- GAP_CYCLES, 1, cycles of all-ones inserted after each hold; legal range 0..255

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- code_in  input  4  line code; 0 = none, 1..8 = line (code-1), 9..15 = illegal
- code_valid  input  1  code_in is valid this cycle
- code_ready  output  1  block can accept a code; high only in IDLE
- out_n  output  8  active-low one-hot line pattern, registered
- busy  output  1  high in HOLD or GAP
- err  output  1  sticky flag: an illegal code was accepted
- err_clr  input  1  synchronous clear of err

One clock; reset is asynchronous and active-low.

## Operation
- States: IDLE, HOLD, GAP.
- Accept occurs on a rising edge with code_valid & code_ready.
- code_ready is driven combinationally as (state == IDLE). It does not depend on code_valid.
- IDLE, accept of a legal code c (0..8):
  - Next cycle, out_n = ~(8'b1 << (c-1)) for c ≥ 1, or 8'hFF for c = 0.
  - State goes to HOLD and the counter loads HOLD_CYCLES-1.
  - Code 0 still occupies a full HOLD slot as a blank.
- IDLE, accept of an illegal code (9..15):
  - err is set on the next edge.
  - out_n stays 8'hFF and the state stays IDLE.
  - code_ready stays high.
- HOLD:
  - out_n is held and the counter decrements each cycle.
  - At count 0: if GAP_CYCLES > 0, out_n goes to 8'hFF, the state goes to GAP and the counter loads GAP_CYCLES-1.
  - At count 0 with GAP_CYCLES = 0: out_n goes to 8'hFF and the state goes to IDLE.
- GAP: out_n = 8'hFF and the counter decrements. At count 0 the state goes to IDLE.
- code_valid and code_in are ignored outside IDLE. A producer holding valid simply waits.
- err_clr clears err on the next edge. If err_clr coincides with an illegal-code accept, set wins (err = 1).
- Counter width is 8 bits. There is no arithmetic wrap: values load from parameters and decrement to 0 only.
- Invariants:
  - At most one bit of out_n is 0 at any time.
  - out_n ≠ 8'hFF implies state HOLD.
  - busy = (state ≠ IDLE).

## Timing
- Reset values: state IDLE, out_n 8'hFF, err 0, counter 0, busy 0, code_ready 1. All are applied asynchronously on rst_n low.
- Reset asserted mid-HOLD or mid-GAP forces out_n to 8'hFF immediately, without waiting for a clock edge. The state returns to IDLE.
- Latency: accept edge T → pattern visible after edge T, for cycles T+1 .. T+HOLD_CYCLES.
- Gap: cycles T+HOLD_CYCLES+1 .. T+HOLD_CYCLES+GAP_CYCLES.
- code_ready rises at cycle T+HOLD_CYCLES+GAP_CYCLES+1.
- Maximum throughput: one code per HOLD_CYCLES+GAP_CYCLES+1 cycles.
- Illegal-code accept costs 1 cycle. A back-to-back valid code is accepted on the very next edge.

## Test plan
- Reset then idle: hold rst_n low for 3 cycles, release → out_n = 8'hFF, code_ready = 1, err = 0, busy = 0.
- Legal code, defaults (HOLD 4, GAP 1): accept code 3 at edge T → out_n = 8'b11111011 for cycles T+1..T+4, out_n = 8'hFF at T+5, code_ready = 1 at T+6.
- Sweep codes 1..8 with continuous valid: feed out_n into the 8-line priority encoder → encoder output equals the accepted code during each HOLD window and 0 during GAP. Code 8 → out_n = 8'b01111111.
- Code 0 and illegal codes:
  - Accept 0 → out_n stays 8'hFF, busy = 1 for 4 cycles.
  - Accept 12 → err = 1 next cycle, busy = 0.
  - A subsequent code 5 is accepted on the next edge.
- err_clr: err_clr together with an accept of code 15 → err remains 1. err_clr alone on the next cycle → err = 0.
- Reset mid-operation: accept code 6, drop rst_n during HOLD cycle 2 → out_n = 8'hFF asynchronously. After release, state is IDLE and code_ready = 1. With GAP_CYCLES = 0, code 2 → code_ready returns 1 at T+5.

Source files
------------

// File: rtl/priority_decoder.sv
// priority_decoder: replays 4-bit line codes as timed active-low one-hot patterns
module priority_decoder #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  output logic [7:0] out_n,
  output logic       busy,
  output logic       err,
  input  logic       err_clr
);
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx, out_nx;
  logic       err_nx, acc, legal;
  assign code_ready = state == IDLE;
  assign busy       = state != IDLE;
  assign acc        = code_valid & code_ready;
  assign legal      = code_in <= 4'd8;
  // next state, counter, pattern and sticky error; illegal accepts beat err_clr
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    out_nx   = (state == HOLD && cnt != 8'd0) ? out_n : 8'hFF;
    err_nx   = (acc & ~legal) | (err & ~err_clr);
    case (state)
      IDLE: if (acc && legal) begin
        state_nx = HOLD;
        cnt_nx   = HOLD_LD;
        out_nx   = code_in == 4'd0 ? 8'hFF : ~(8'd1 << (code_in - 4'd1));
      end
      HOLD: if (cnt == 8'd0) begin
        state_nx = GAP_CYCLES > 0 ? GAP : IDLE;
        cnt_nx   = GAP_LD;
      end else cnt_nx = cnt - 8'd1;
      GAP: if (cnt == 8'd0) state_nx = IDLE;
      else cnt_nx = cnt - 8'd1;
      default: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end
  // state registers with asynchronous return to idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      out_n <= 8'hFF;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      out_n <= out_nx;
      err   <= err_nx;
    end
endmodule

// File: tb/tb_priority_decoder.sv
// tb_priority_decoder: vector table, directed corners and random run against a queue model
module tb_priority_decoder;
  localparam int H = 4;
  localparam int G = 1;
  logic       clk = 0, rst_n = 0;
  logic [3:0] code_in = 0, code_in0 = 0;
  logic       code_valid = 0, code_valid0 = 0, err_clr = 0, err_clr0 = 0;
  logic       code_ready, busy, err, code_ready0, busy0, err0;
  logic [7:0] out_n, out_n0;
  int nchk = 0, nerr = 0;
  logic [7:0] q[$];
  logic       m_err = 0, m_idle, m_set;
  typedef struct {logic [3:0] code; logic [7:0] out; logic e; logic b;} vec_t;
  vec_t vt[6];

  priority_decoder #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .out_n(out_n), .busy(busy), .err(err), .err_clr(err_clr));
  priority_decoder #(.HOLD_CYCLES(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .code_in(code_in0), .code_valid(code_valid0),
    .code_ready(code_ready0), .out_n(out_n0), .busy(busy0), .err(err0), .err_clr(err_clr0));

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(int c);
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = !(c == i + 1);
    return p;
  endfunction

  function automatic int enc(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (!v[i]) return i + 1;
    return 0;
  endfunction

  // each accepted legal code schedules H pattern cycles then G blank cycles
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.delete();
      m_err = 0;
    end else begin
      m_idle = q.size() == 0;
      if (!m_idle) void'(q.pop_front());
      m_set = m_idle && code_valid && code_in > 8;
      if (m_idle && code_valid && code_in <= 8) begin
        for (int i = 0; i < H; i++) q.push_back(pat(code_in));
        for (int i = 0; i < G; i++) q.push_back(8'hFF);
      end
      m_err = m_set ? 1'b1 : err_clr ? 1'b0 : m_err;
    end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(int e);
    @(negedge clk);
    chk("out_n", out_n, q.size() ? q[0] : 8'hFF);
    chk("busy", busy, q.size() != 0);
    chk("ready", code_ready, q.size() == 0);
    chk("err", err, m_err);
    if (e >= 0) chk("enc", enc(out_n), e);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!code_ready && n < 600) begin
      tick(-1);
      n++;
    end
    if (!code_ready) chk("ready_timeout", 0, 1);
  endtask

  initial begin
    vt[0] = '{4'd3, 8'hFB, 1'b0, 1'b1};
    vt[1] = '{4'd8, 8'h7F, 1'b0, 1'b1};
    vt[2] = '{4'd1, 8'hFE, 1'b0, 1'b1};
    vt[3] = '{4'd0, 8'hFF, 1'b0, 1'b1};
    vt[4] = '{4'd12, 8'hFF, 1'b1, 1'b0};
    vt[5] = '{4'd5, 8'hEF, 1'b0, 1'b1};
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_out", out_n, 8'hFF);
    chk("rst_ready", code_ready, 1);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      wait_ready();
      err_clr = 1;
      tick(-1);
      err_clr = 0;
      code_in = vt[i].code;
      code_valid = 1;
      tick(-1);
      code_valid = 0;
      chk("vec_out", out_n, vt[i].out);
      chk("vec_err", err, vt[i].e);
      chk("vec_busy", busy, vt[i].b);
    end
    wait_ready();
    code_in = 3;
    code_valid = 1;
    tick(-1);
    code_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      chk("c3_hold", out_n, 8'hFB);
      tick(-1);
    end
    chk("c3_gap", out_n, 8'hFF);
    chk("c3_gap_ready", code_ready, 0);
    tick(-1);
    chk("c3_ready", code_ready, 1);
    code_valid = 1;
    for (int k = 1; k <= 8; k++) begin
      code_in = 4'(k);
      wait_ready();
      tick(-1);
      if (k == 8) chk("c8_out", out_n, 8'h7F);
      for (int j = 0; j < H; j++) tick(k);
      for (int j = 0; j < G; j++) tick(0);
    end
    code_valid = 0;
    code_in = 0;
    code_valid = 1;
    tick(-1);
    code_valid = 0;
    for (int j = 0; j < 4; j++) begin
      chk("c0_out", out_n, 8'hFF);
      chk("c0_busy", busy, 1);
      tick(-1);
    end
    wait_ready();
    code_in = 12;
    code_valid = 1;
    tick(-1);
    chk("ill_err", err, 1);
    chk("ill_busy", busy, 0);
    chk("ill_ready", code_ready, 1);
    code_in = 5;
    tick(-1);
    code_valid = 0;
    chk("b2b_out", out_n, 8'hEF);
    wait_ready();
    code_in = 15;
    code_valid = 1;
    err_clr = 1;
    tick(-1);
    code_valid = 0;
    chk("clr_set_wins", err, 1);
    tick(-1);
    err_clr = 0;
    chk("clr_alone", err, 0);
    code_in = 6;
    code_valid = 1;
    tick(-1);
    code_valid = 0;
    tick(-1);
    chk("c6_hold2", out_n, 8'hDF);
    #2 rst_n = 0;
    #1;
    chk("arst_out", out_n, 8'hFF);
    chk("arst_busy", busy, 0);
    chk("arst_ready", code_ready, 1);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", code_ready, 1);
    chk("post_rst_out", out_n, 8'hFF);
    code_in0 = 2;
    code_valid0 = 1;
    @(posedge clk);
    #1 code_valid0 = 0;
    for (int j = 1; j <= 4; j++) begin
      chk("g0_out", out_n0, 8'hFD);
      chk("g0_ready_low", code_ready0, 0);
      @(posedge clk);
      #1;
    end
    chk("g0_ready", code_ready0, 1);
    chk("g0_idle_out", out_n0, 8'hFF);
    chk("g0_err", err0, 0);
    chk("g0_busy", busy0, 0);
    for (int i = 0; i < 400; i++) begin
      code_valid = 1'($urandom_range(0, 1));
      code_in = 4'($urandom_range(0, 15));
      err_clr = $urandom_range(0, 7) == 0;
      tick(-1);
    end
    code_valid = 0;
    err_clr = 0;
    tick(-1);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
